// File: rtl/adc_bcd_converter.sv
// Scales a 12-bit XADC code to 0..1000000 and converts it to 7 BCD digits by sequential double-dabble.
// Define ADC_BCD_AVG_EN to average four accepted codes per conversion.
module adc_bcd_converter (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        busy,
    output logic        digits_valid,
    output logic [27:0] bcd
);
    localparam int CODE_W  = 12;
    localparam int VALUE_W = 20;
    localparam int DIGITS  = 7;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int SHIFT_W = BCD_W + VALUE_W;
    localparam int ITERS   = VALUE_W;

    typedef enum logic [1:0] {IDLE, SCALE, CONVERT, DONE} state_t;

    state_t              state_q;
    logic [CODE_W-1:0]   code_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic [SHIFT_W-1:0]  shift_d;
    logic [4:0]          iter_q;
    logic                busy_q;
    logic                valid_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                unused_nibble;

`ifdef ADC_BCD_AVG_EN
    logic [13:0]         acc_q;
    logic [13:0]         acc_d;
    logic [1:0]          cnt_q;

    assign acc_d = acc_q + 14'(sample_data[15:4]);
`endif

    assign unused_nibble = ^sample_data[3:0];

    // Codes at the top of the range clip to exactly full scale.
    function automatic logic [VALUE_W-1:0] scale_code(input logic [CODE_W-1:0] code);
        logic [29:0] product;
        product = 30'(code) * 30'd250000;
        if (code >= 12'd4093) return 20'd1000000;
        return product[29:10];
    endfunction

    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] sr);
        logic [SHIFT_W-1:0] adj;
        adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[VALUE_W + 4*d +: 4] >= 4'd5)
                adj[VALUE_W + 4*d +: 4] = adj[VALUE_W + 4*d +: 4] + 4'd3;
        end
        return {adj[SHIFT_W-2:0], 1'b0};
    endfunction

    assign shift_d = dabble_step(shift_q);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            code_q  <= '0;
            shift_q <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
`ifdef ADC_BCD_AVG_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sample_valid) begin
`ifdef ADC_BCD_AVG_EN
                        if (cnt_q == 2'd3) begin
                            code_q  <= acc_d[13:2];
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= SCALE;
                            busy_q  <= 1'b1;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + 2'd1;
                        end
`else
                        code_q  <= sample_data[15:4];
                        state_q <= SCALE;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                SCALE: begin
                    shift_q <= {{BCD_W{1'b0}}, scale_code(code_q)};
                    iter_q  <= '0;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    shift_q <= shift_d;
                    iter_q  <= iter_q + 5'd1;
                    if (iter_q == 5'(ITERS - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    bcd_q   <= shift_q[SHIFT_W-1:VALUE_W];
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign digits_valid = valid_q;
    assign bcd          = bcd_q;
endmodule

// File: tb/tb_adc_bcd_converter.sv
// Self-checking bench for adc_bcd_converter: vector table, corner sequences and randomized samples vs. an arithmetic model.
module tb_adc_bcd_converter;
    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        busy;
    logic        digits_valid;
    logic [27:0] bcd;

    int          n_total;
    int          n_pass;
    logic [27:0] last_bcd;

    adc_bcd_converter dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .digits_valid (digits_valid),
        .bcd          (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [27:0] exp;
    } vec_t;

    function automatic logic [27:0] ref_bcd(input int code);
        int v;
        logic [27:0] r;
        v = (code >= 4093) ? 1000000 : (code * 250000) / 1024;
        r = '0;
        for (int d = 0; d < 7; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [27:0] b);
        for (int d = 0; d < 7; d++)
            if (b[4*d +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Wait for the digits_valid pulse after acceptance; optionally pulse sample_valid once at cycle inj_k.
    task automatic wait_result(input string nm, input logic [27:0] exp, input int inj_k, input logic [15:0] inj_data);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        while (k < 40 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (inj_k > 0 && k == inj_k + 1) sample_valid = 1'b0;
            if (inj_k > 0 && k == inj_k) begin
                sample_valid = 1'b1;
                sample_data  = inj_data;
            end
            if (k == 10) chk({nm, " hold"}, 32'(bcd), 32'(last_bcd));
            if (digits_valid) seen = 1'b1;
        end
        chk({nm, " latency"}, 32'(k), 32'd22);
        chk({nm, " bcd"}, 32'(bcd), 32'(exp));
        chk({nm, " nibbles"}, 32'(bcd_ok(bcd)), 32'd1);
        chk({nm, " busy_done"}, 32'(busy), 32'd0);
        last_bcd = exp;
    endtask

    task automatic send(input logic [15:0] data);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = data;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic run_conv(input string nm, input logic [15:0] data, input logic [27:0] exp,
                            input int inj_k, input logic [15:0] inj_data);
        send(data);
        wait_result(nm, exp, inj_k, inj_data);
    endtask

    task automatic no_pulse(input string nm, input int cycles);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (digits_valid) pulses++;
        end
        chk({nm, " no_extra_pulse"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[6];
        logic [15:0] d;
        n_total      = 0;
        n_pass       = 0;
        last_bcd     = '0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;

        vt[0] = '{16'h0000, 28'h0000000};
        vt[1] = '{16'h0010, 28'h0000244};
        vt[2] = '{16'h8000, 28'h0500000};
        vt[3] = '{16'hFFD0, 28'h1000000};
        vt[4] = '{16'hFFF0, 28'h1000000};
        vt[5] = '{16'hFFC0, 28'h0999023};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(digits_valid), 32'd0);
        chk("reset bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ADC_BCD_AVG_EN
        begin
            logic [15:0] g[4];
            int          sum;
            g = '{16'h0640, 16'h0C80, 16'h12C0, 16'h1900};
            for (int i = 0; i < 3; i++) begin
                send(g[i]);
                chk("avg partial busy", 32'(busy), 32'd0);
            end
            send(g[3]);
            wait_result("avg 100..400", 28'h0061035, 0, 16'h0);
            for (int t = 0; t < 8; t++) begin
                sum = 0;
                for (int i = 0; i < 4; i++) begin
                    d = 16'($urandom);
                    sum += int'(d[15:4]);
                    send(d);
                end
                wait_result("avg random", ref_bcd(sum / 4), 0, 16'h0);
            end
        end
`else
        for (int i = 0; i < 6; i++)
            run_conv($sformatf("table%0d", i), vt[i].data, vt[i].exp, 0, 16'h0);

        // Second strobe while busy must vanish without a trace.
        run_conv("drop_busy", 16'h0010, 28'h0000244, 5, 16'hFFF0);
        no_pulse("drop_busy", 30);

        // A strobe landing in DONE is dropped too.
        run_conv("drop_done", 16'h8000, 28'h0500000, 21, 16'h0010);
        no_pulse("drop_done", 30);

        // Reset in the 10th CONVERT cycle aborts silently.
        send(16'hFFF0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort bcd", 32'(bcd), 32'd0);
        chk("abort valid", 32'(digits_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_bcd = '0;
        no_pulse("abort", 30);
        run_conv("after_abort", 16'hFFC0, 28'h0999023, 0, 16'h0);

        for (int t = 0; t < 30; t++) begin
            d = 16'($urandom);
            if (t % 5 == 0) d[15:8] = 8'hFF;
            run_conv($sformatf("rand%0d", t), d, ref_bcd(int'(d[15:4])), 0, 16'h0);
        end
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adc_bcd_converter.md
ADC_BCD_CONVERTER -- requirements
Module: adc_bcd_converter

Interface
REQ-001 SHALL provide port CLK100MHZ, input, 1 bit: the single system clock, 100 MHz; all logic is on its rising edge.
REQ-002 SHALL provide port CPU_RESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL provide port sample_valid, input, 1 bit: a one-cycle strobe qualifying sample_data (driven from the XADC drdy_out).
REQ-004 SHALL provide port sample_data, input, 16 bits: the XADC do_out word; the 12-bit code is in [15:4] and [3:0] is ignored.
REQ-005 SHALL provide port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 SHALL provide port digits_valid, output, 1 bit: a one-cycle pulse when bcd updates.
REQ-007 SHALL provide port bcd, output, 28 bits: 7 BCD digits, digit0 (least significant) in [3:0] up to digit6 in [27:24].

Function
REQ-008 SHALL use states IDLE, SCALE, CONVERT and DONE.
REQ-009 SHALL accept a sample only when sample_valid=1 and state=IDLE.
REQ-010 SHALL silently drop a sample that arrives in any other state, with no queuing.
REQ-011 SHALL, in IDLE on accept, latch code=sample_data[15:4] and go to SCALE.
REQ-012 SHALL, in SCALE (1 cycle), compute a 20-bit value=(code*250000)>>10, truncated, with a full-width intermediate product.
REQ-013 SHALL saturate in SCALE: if code>=4093, value=1000000 regardless of the product.
REQ-014 SHALL, in CONVERT, perform sequential double-dabble: 20 iterations, one shift per cycle; before each shift, every 4-bit digit >=5 gets +3.
REQ-015 SHALL, in DONE (1 cycle), load bcd from the shift register, pulse digits_valid, and return to IDLE.
REQ-016 SHALL keep latency fixed: sample accepted at edge N, then digits_valid high and bcd valid in the cycle after edge N+22.
REQ-017 SHALL drive busy=1 in SCALE and CONVERT, and busy=0 in IDLE and DONE.
REQ-018 SHALL hold bcd stable between digits_valid pulses.
REQ-019 SHALL produce no invalid BCD nibble (>9) on bcd, ever.
REQ-020 SHALL accept a sample_valid arriving in the same cycle as the DONE pulse only if the state is IDLE; in DONE it is dropped.
REQ-021 SHALL accept a new sample in the first IDLE cycle after DONE, giving a back-to-back throughput of one conversion per 23 cycles.

Reset
REQ-022 SHALL, on CPU_RESETN low, immediately force state=IDLE, busy=0, digits_valid=0, bcd=0, and clear the iteration counter, shift register and accumulator.
REQ-023 SHALL abort any conversion in progress on reset mid-operation, producing no digits_valid pulse for it.
REQ-024 SHALL, after release, accept the first sample_valid seen in IDLE.

Configuration
REQ-025 SHALL implement macro ADC_BCD_AVG_EN.
REQ-026 SHALL, with ADC_BCD_AVG_EN defined, add each accepted IDLE code into a 14-bit accumulator.
REQ-027 SHALL, with ADC_BCD_AVG_EN defined, leave IDLE only on the 4th accepted code, using code=accumulator>>2 for SCALE and the saturation check, then clear the accumulator and the 2-bit sample counter.
REQ-028 SHALL, with ADC_BCD_AVG_EN defined, drop samples arriving while busy without adding them to the accumulator.
REQ-029 SHALL, without ADC_BCD_AVG_EN, omit the accumulator and counter and convert every accepted sample individually, as in REQ-011.

Verification
REQ-030 SHALL cover: sample_data=16'h0000 -> after 23 cycles, one digits_valid pulse, bcd=28'h0000000.
REQ-031 SHALL cover: sample_data=16'h0010 (code 1) -> bcd=28'h0000244; sample_data=16'h8000 (code 2048) -> bcd=28'h0500000.
REQ-032 SHALL cover: sample_data=16'hFFD0 (code 4093) and 16'hFFF0 (code 4095) -> bcd=28'h1000000 each; 16'hFFC0 (code 4092) -> bcd=28'h0999023.
REQ-033 SHALL cover: second sample_valid 5 cycles after the first -> ignored, exactly one digits_valid pulse, bcd reflects the first sample only.
REQ-034 SHALL cover: CPU_RESETN low at cycle 10 of CONVERT -> busy=0 and bcd=0 at once, no digits_valid pulse; the next sample converts correctly.
REQ-035 SHALL cover, with ADC_BCD_AVG_EN: codes 100, 200, 300, 400 (sample_data 16'h0640, 16'h0C80, 16'h12C0, 16'h1900) -> a single pulse after the 4th, bcd=28'h0061035.
